// File: rtl/snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// snake_step_ctrl
//
// Game-tick sequencer for the snake move datapath. It does four things:
//   - counts out a step period of TICK_CYCLES clocks;
//   - latches player direction requests and rejects 180-degree reversals;
//   - probes the next head tile for a wall or body collision;
//   - emits a one-cycle direction pulse to move, or parks in DEAD.
//
// Direction encoding (shared with the keyboard decoder and move):
//   0 = NONE, 1 = UP, 2 = DOWN, 3 = LEFT, 4 = RIGHT
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        start/restart request (level, honoured in IDLE/DEAD only)
//   pause_i        freezes the tick counter while in WAIT
//   key_valid_i    one-cycle strobe qualifying key_dir_i
//   key_dir_i      requested direction
//   head_x_i/_y_i  current head position from move
//   probe_hit_i    tile at (probe_x_o, probe_y_o) is non-empty (combinational)
//   probe_x_o/_y_o registered probe coordinates (head + step direction)
//   move_dir_o     direction pulse to move.dir, NONE outside STEP
//   map_rst_o      one-cycle reinitialise pulse for move on a start
//   running_o      high in WAIT, CHECK and STEP
//   game_over_o    high in DEAD
//   step_count_o   completed steps, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module snake_step_ctrl #(
  parameter int TICK_CYCLES = 6_500_000,
  parameter int MAP_WIDTH   = 32,
  parameter int MAP_HEIGHT  = 24,
  parameter int X_W         = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1,
  parameter int Y_W         = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           pause_i,
  input  logic           key_valid_i,
  input  logic [2:0]     key_dir_i,
  input  logic [X_W-1:0] head_x_i,
  input  logic [Y_W-1:0] head_y_i,
  input  logic           probe_hit_i,
  output logic [X_W-1:0] probe_x_o,
  output logic [Y_W-1:0] probe_y_o,
  output logic [2:0]     move_dir_o,
  output logic           map_rst_o,
  output logic           running_o,
  output logic           game_over_o,
  output logic [15:0]    step_count_o
);

  // Direction codes
  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  // FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_STEP  = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  localparam int             CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [X_W-1:0] X_MAX     = X_W'(MAP_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX     = Y_W'(MAP_HEIGHT - 1);

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [2:0]       heading_q,    heading_d;
  logic [2:0]       pending_q,    pending_d;
  logic [2:0]       step_dir_q,   step_dir_d;
  logic             wall_q,       wall_d;
  logic [X_W-1:0]   probe_x_q,    probe_x_d;
  logic [Y_W-1:0]   probe_y_q,    probe_y_d;
  logic [15:0]      step_count_q, step_count_d;

  // ---------------------------------------------------------------------------
  // Probe target for the pending direction. Coordinates use plain field-width
  // arithmetic, so a wall move wraps; the wrapped value is never used because
  // the wall flag forces DEAD regardless of probe_hit_i.
  // ---------------------------------------------------------------------------
  logic [X_W-1:0] tgt_x;
  logic [Y_W-1:0] tgt_y;
  logic           tgt_wall;

  always_comb begin
    tgt_x    = head_x_i;
    tgt_y    = head_y_i;
    tgt_wall = 1'b0;
    case (pending_q)
      DIR_UP: begin
        tgt_y    = head_y_i - Y_W'(1);
        tgt_wall = (head_y_i == '0);
      end
      DIR_DOWN: begin
        tgt_y    = head_y_i + Y_W'(1);
        tgt_wall = (head_y_i == Y_MAX);
      end
      DIR_LEFT: begin
        tgt_x    = head_x_i - X_W'(1);
        tgt_wall = (head_x_i == '0);
      end
      DIR_RIGHT: begin
        tgt_x    = head_x_i + X_W'(1);
        tgt_wall = (head_x_i == X_MAX);
      end
      default: ;
    endcase
  end

  // Keys are checked against the committed heading, not pending, so two
  // quick turns can never fold the snake back onto its own neck.
  logic in_game;
  logic key_ok;

  assign in_game = (state_q == ST_WAIT) || (state_q == ST_CHECK) ||
                   (state_q == ST_STEP);
  assign key_ok  = in_game && key_valid_i &&
                   (key_dir_i inside {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}) &&
                   (key_dir_i != opposite(heading_q));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    heading_d    = heading_q;
    pending_d    = pending_q;
    step_dir_d   = step_dir_q;
    wall_d       = wall_q;
    probe_x_d    = probe_x_q;
    probe_y_d    = probe_y_q;
    step_count_d = step_count_q;

    case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (start_i) begin
          state_d      = ST_WAIT;
          cnt_d        = '0;
          step_count_d = '0;
          heading_d    = DIR_UP;
          pending_d    = DIR_UP;
        end
      end

      ST_WAIT: begin
        if (!pause_i) begin
          if (cnt_q == TICK_LAST) begin
            // Tick boundary: freeze the direction for this step and register
            // the probe so the map lookup sees stable coordinates in CHECK.
            state_d    = ST_CHECK;
            cnt_d      = '0;
            step_dir_d = pending_q;
            probe_x_d  = tgt_x;
            probe_y_d  = tgt_y;
            wall_d     = tgt_wall;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // The tail tile counts as a hit: length is fixed, no tail exemption.
      ST_CHECK: state_d = (wall_q || probe_hit_i) ? ST_DEAD : ST_STEP;

      ST_STEP: begin
        state_d   = ST_WAIT;
        heading_d = step_dir_q;
        if (step_count_q != 16'hFFFF) step_count_d = step_count_q + 16'd1;
      end

      default: state_d = ST_IDLE;
    endcase

    // A key on the tick-boundary cycle lands in pending after step_dir has
    // already sampled it, so it applies to the following step.
    if (key_ok) pending_d = key_dir_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      heading_q    <= DIR_UP;
      pending_q    <= DIR_UP;
      step_dir_q   <= DIR_UP;
      wall_q       <= 1'b0;
      probe_x_q    <= '0;
      probe_y_q    <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      heading_q    <= heading_d;
      pending_q    <= pending_d;
      step_dir_q   <= step_dir_d;
      wall_q       <= wall_d;
      probe_x_q    <= probe_x_d;
      probe_y_q    <= probe_y_d;
      step_count_q <= step_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // map_rst is decoded in the start cycle itself so move is reinitialised on
  // the same edge the FSM enters WAIT; the first step then lands
  // TICK_CYCLES + 2 cycles after this pulse.
  assign map_rst_o    = !rst && start_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DEAD));
  assign move_dir_o   = (state_q == ST_STEP) ? step_dir_q : DIR_NONE;
  assign running_o    = in_game;
  assign game_over_o  = (state_q == ST_DEAD);
  assign probe_x_o    = probe_x_q;
  assign probe_y_o    = probe_y_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with TICK_CYCLES=4 on an 8x8 map.
module tb_snake_step_ctrl;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] DOWN  = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        key_valid = 1'b0;
  logic [2:0]  key_dir = NONE;
  logic [2:0]  head_x = 3'd4;
  logic [2:0]  head_y = 3'd4;
  logic        probe_hit = 1'b0;
  logic [2:0]  probe_x;
  logic [2:0]  probe_y;
  logic [2:0]  move_dir;
  logic        map_rst;
  logic        running;
  logic        game_over;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  logic [2:0] d;

  snake_step_ctrl #(.TICK_CYCLES(4), .MAP_WIDTH(8), .MAP_HEIGHT(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .pause_i(pause),
    .key_valid_i(key_valid), .key_dir_i(key_dir),
    .head_x_i(head_x), .head_y_i(head_y), .probe_hit_i(probe_hit),
    .probe_x_o(probe_x), .probe_y_o(probe_y), .move_dir_o(move_dir),
    .map_rst_o(map_rst), .running_o(running), .game_over_o(game_over),
    .step_count_o(step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [2:0] kd);
    key_valid = 1'b1;
    key_dir   = kd;
    tick();
    key_valid = 1'b0;
    key_dir   = NONE;
  endtask

  // Ticks until a move pulse or DEAD; returns ticks taken and move_dir seen.
  task automatic run_to_step(output int cnt, output logic [2:0] dd);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (move_dir == NONE && !game_over && cnt < 100);
    dd = move_dir;
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    chk("map_rst_pulse", map_rst, 1);
    tick();
    start = 1'b0;
    #1;
    chk("map_rst_once", map_rst, 0);
    chk("running_after_start", running, 1);
  endtask

  initial begin
    // ---- reset state
    tick(); tick();
    chk("rst_move_dir", move_dir, NONE);
    chk("rst_map_rst", map_rst, 0);
    chk("rst_running", running, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_probe_x", probe_x, 0);
    chk("rst_probe_y", probe_y, 0);
    rst = 1'b0;
    tick();

    // ---- basic step: UP pulse every 6 cycles, count 1,2
    do_start();
    run_to_step(n, d);
    chk("first_step_lat", n, 5);
    chk("first_step_dir", d, UP);
    chk("first_probe_x", probe_x, 4);
    chk("first_probe_y", probe_y, 3);
    chk("count_in_step", step_count, 0);
    tick();
    chk("pulse_one_cycle", move_dir, NONE);
    chk("count1", step_count, 1);
    run_to_step(n, d);
    chk("period2", n, 5);
    chk("dir2", d, UP);
    tick();
    chk("count2", step_count, 2);

    // ---- reversal reject, then LEFT accepted, then RIGHT rejected
    key(DOWN);
    run_to_step(n, d);
    chk("rev_lat", n, 4);
    chk("rev_dir", d, UP);
    tick();
    key(LEFT);
    run_to_step(n, d);
    chk("left_dir", d, LEFT);
    chk("left_probe_x", probe_x, 3);
    tick();
    key(RIGHT);
    run_to_step(n, d);
    chk("right_rej_dir", d, LEFT);
    tick();

    // ---- last key wins (heading LEFT: UP then DOWN -> DOWN)
    key(UP);
    key(DOWN);
    run_to_step(n, d);
    chk("lkw_lat", n, 3);
    chk("lkw_dir", d, DOWN);
    chk("lkw_probe_y", probe_y, 5);
    tick();
    // key on the WAIT->CHECK edge cycle applies one step later
    tick(); tick(); tick();
    key(LEFT);
    run_to_step(n, d);
    chk("edge_lat", n, 1);
    chk("edge_dir_now", d, DOWN);
    tick();
    run_to_step(n, d);
    chk("edge_dir_next", d, LEFT);
    tick();
    chk("count8", step_count, 8);

    // ---- pause 10 cycles delays the step by exactly 10
    pause = 1'b1;
    repeat (10) tick();
    chk("pause_no_step", move_dir, NONE);
    chk("pause_running", running, 1);
    pause = 1'b0;
    run_to_step(n, d);
    chk("pause_lat", n, 5);
    chk("pause_dir", d, LEFT);

    // ---- reset during STEP
    rst = 1'b1;
    tick();
    chk("mid_rst_move_dir", move_dir, NONE);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_count", step_count, 0);
    chk("mid_rst_probe_x", probe_x, 0);
    chk("mid_rst_game_over", game_over, 0);
    rst = 1'b0;
    tick();

    // ---- top wall moving UP
    head_x = 3'd4; head_y = 3'd0;
    do_start();
    run_to_step(n, d);
    chk("wall_up_lat", n, 5);
    chk("wall_up_dir", d, NONE);
    chk("wall_up_dead", game_over, 1);
    chk("wall_up_running", running, 0);
    tick();
    chk("dead_holds", game_over, 1);
    chk("dead_move_dir", move_dir, NONE);

    // ---- right wall moving RIGHT
    head_x = 3'd7; head_y = 3'd3;
    do_start();
    chk("restart_count", step_count, 0);
    key(RIGHT);
    run_to_step(n, d);
    chk("wall_r_lat", n, 4);
    chk("wall_r_dir", d, NONE);
    chk("wall_r_dead", game_over, 1);

    // ---- body hit; restart heads UP again
    head_x = 3'd4; head_y = 3'd4;
    probe_hit = 1'b1;
    do_start();
    run_to_step(n, d);
    chk("body_lat", n, 5);
    chk("body_dir", d, NONE);
    chk("body_dead", game_over, 1);
    chk("body_probe_y", probe_y, 3);
    probe_hit = 1'b0;
    do_start();
    chk("restart_game_over", game_over, 0);
    chk("restart_count2", step_count, 0);
    run_to_step(n, d);
    chk("restart_dir", d, UP);
    tick();
    chk("restart_count_after", step_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snake_step_ctrl.md
# snake_step_ctrl

Game-tick sequencer for the snake `move` datapath. It generates the periodic step tick and latches player direction requests, rejecting 180° reversals. Before each step it probes the target head tile for wall or body collision. On a safe step it issues a one-cycle direction pulse to `move.dir`; otherwise it enters a terminal DEAD state. It sits between the keyboard decoder and `move`, and drives the map-lookup port used for collision checks.

## Interface

Parameters:
- `TICK_CYCLES`, default 6_500_000: clk cycles spent in WAIT per step (≥ 1).
- `MAP_WIDTH`, `MAP_HEIGHT`, default snake_pkg values: map bounds used for the wall check.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: start/restart request, level-sampled.
- `pause`, in, 1: freezes the tick counter while high.
- `key_valid`, in, 1: one-cycle strobe qualifying `key_dir`.
- `key_dir`, in, direction (snake_pkg): requested direction.
- `head_x`, `head_y`, in, map_s head field widths: current head position from `move`.
- `probe_hit`, in, 1: tile at (`probe_x`, `probe_y`) is non-EMPTY; driven combinationally by the map lookup.
- `probe_x`, `probe_y`, out, head field widths: registered probe coordinates.
- `move_dir`, out, direction: connects to `move.dir`. It is NONE except during STEP.
- `map_rst`, out, 1: one-cycle pulse that reinitialises `move`; OR'd with `rst` at `move`.
- `running`, out, 1: high in WAIT, CHECK and STEP.
- `game_over`, out, 1: high in DEAD.
- `step_count`, out, 16: count of completed steps, saturating at 0xFFFF.

## Operation

States are IDLE, WAIT, CHECK, STEP and DEAD.

Reset values:
- State = IDLE.
- `move_dir` = NONE.
- `map_rst` = 0, `running` = 0, `game_over` = 0, `step_count` = 0.
- `probe_x` = `probe_y` = 0.
- `heading` = `pending` = UP.
- Tick counter = 0.

IDLE / DEAD with `start`=1:
- Pulse `map_rst` for one cycle and go to WAIT.
- Clear the counter and `step_count`.
- Set `heading` = `pending` = UP (the start orientation).
- `start` is ignored in WAIT, CHECK and STEP.

WAIT:
- The counter increments each cycle unless `pause`=1; while paused it holds.
- When the counter is TICK_CYCLES-1 and `pause`=0, go to CHECK and clear the counter.
- On the same edge, latch `step_dir` = `pending` and register the probe target as head + `step_dir`:
  - UP: y-1.
  - DOWN: y+1.
  - LEFT: x-1.
  - RIGHT: x+1.

Wall check:
- Computed at the same edge as the probe latch, into a registered `wall` flag.
- It is set for UP with head_y=0, LEFT with head_x=0, RIGHT with head_x=MAP_WIDTH-1, and DOWN with head_y=MAP_HEIGHT-1.
- On a wall hit the probe coordinates wrap modulo the field width. The value is don't-care.

CHECK (one cycle):
- If `wall` | `probe_hit`, go to DEAD. The tail tile counts as a hit, since length is fixed and no tail exemption is made.
- Otherwise go to STEP.

STEP (one cycle):
- `move_dir` = `step_dir`.
- `heading` ← `step_dir`.
- `step_count` increments, saturating.
- Next state is WAIT.

DEAD:
- `move_dir` = NONE. The map is frozen.
- Wait for `start`.

Direction latch (all states except IDLE and DEAD):
- On `key_valid` with `key_dir` ≠ NONE and `key_dir` ≠ opposite(`heading`), set `pending` ← `key_dir`.
- The comparison is against the committed `heading`, not `pending`.
- The last accepted key before the WAIT→CHECK edge wins.
- A key arriving on that edge cycle applies to the next step.
- A key accepted during CHECK or STEP goes to the next step.

`pause` has no effect outside WAIT.

## Timing

- Step period is TICK_CYCLES + 2 cycles with `pause` low: TICK_CYCLES in WAIT, 1 in CHECK, 1 in STEP.
- The `move` head updates on the edge ending STEP, so `head_x`/`head_y` are stable for the whole following WAIT.
- The first STEP after `start` occurs TICK_CYCLES + 2 cycles after the `map_rst` cycle.
- Collision latency: DEAD is entered 1 cycle after the probe is presented, and no `move_dir` pulse is emitted for that step.
- `rst` mid-game returns to IDLE next cycle with all reset values. `move` is reset by the same `rst`.

## Test plan

- **Basic step:** TICK_CYCLES=4, reset, `start`, no keys → `map_rst` pulse once. `move_dir`=UP for exactly 1 cycle every 6 cycles. `step_count` = 1, 2, 3…
- **Reversal reject:** heading UP, key DOWN → ignored, next step UP. Then key LEFT → accepted and the next step is LEFT. Key RIGHT after the LEFT step → rejected.
- **Last-key-wins:** LEFT then RIGHT within one WAIT with heading UP → step RIGHT. A key on the WAIT→CHECK edge cycle applies one step later.
- **Wall:** head_y=0, heading UP, `probe_hit`=0 → DEAD with `game_over`=1 and no `move_dir` pulse. Same for head_x=MAP_WIDTH-1 moving RIGHT.
- **Body hit / restart:** force `probe_hit`=1 in CHECK → DEAD. Then `start` → `map_rst` pulse, `step_count`=0, heading UP, `running`=1.
- **Pause / reset mid-game:** hold `pause` for 10 cycles in WAIT → step delayed by exactly 10 cycles. Assert `rst` during STEP → next cycle IDLE, `move_dir`=NONE, all outputs at reset values.
